// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB forwarding and load-use bubble insertion.
// Optional macro EX_STALL_CNT_EN adds a saturating load-use stall counter output (stall_cnt).
module ex_operand_stage #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [RF_AW-1:0] id_rs1_addr,
   input  logic [RF_AW-1:0] id_rs2_addr,
   input  logic [RF_AW-1:0] id_rd_addr,
   input  logic [6:0]       id_opcode,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7_5,
   input  logic             flush,
   input  logic             hold,
   input  logic             exmem_regwrite,
   input  logic [RF_AW-1:0] exmem_rd,
   input  logic [XLEN-1:0]  exmem_result,
   input  logic             memwb_regwrite,
   input  logic [RF_AW-1:0] memwb_rd,
   input  logic [XLEN-1:0]  memwb_data,
   output logic             load_use_stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  alu_src1,
   output logic [XLEN-1:0]  alu_src2,
   output logic [3:0]       alu_ctrl,
   output logic [RF_AW-1:0] ex_rd,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic [XLEN-1:0]  ex_store_data,
`ifdef EX_STALL_CNT_EN
   output logic [XLEN-1:0]  ex_pc,
   output logic [31:0]      stall_cnt
`else
   output logic [XLEN-1:0]  ex_pc
`endif
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd8;

   typedef enum logic [1:0] {S1_RS, S1_PC, S1_ZERO} src1_sel_e;
   typedef enum logic [1:0] {S2_RS, S2_FOUR, S2_IMM} src2_sel_e;

   logic [3:0] dec_ctrl;
   logic       dec_rw, dec_mr, dec_mw;
   src1_sel_e  dec_s1;
   src2_sel_e  dec_s2;

   logic             valid_q, valid_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [RF_AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [RF_AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [RF_AW-1:0] rd_q, rd_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             regwrite_q, regwrite_d;
   logic             memread_q, memread_d;
   logic             memwrite_q, memwrite_d;
   src1_sel_e        s1_q, s1_d;
   src2_sel_e        s2_q, s2_d;

   logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

   // ID-side decode; it is registered so nothing from id_* reaches the ALU combinationally
   always_comb begin
      dec_ctrl = ALU_ADD;
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_s1   = S1_RS;
      dec_s2   = S2_IMM;
      case (id_opcode)
         OP_R, OP_I: begin
            dec_rw = 1'b1;
            dec_s2 = (id_opcode == OP_R) ? S2_RS : S2_IMM;
            case (id_funct3)
               3'b000:  dec_ctrl = (id_opcode == OP_R && id_funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  dec_ctrl = ALU_SLL;
               3'b010,
               3'b011:  dec_ctrl = ALU_SLT;
               3'b100:  dec_ctrl = ALU_XOR;
               3'b101:  dec_ctrl = id_funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  dec_ctrl = ALU_OR;
               default: dec_ctrl = ALU_AND;
            endcase
         end
         OP_LOAD: begin
            dec_mr = 1'b1;
            dec_rw = 1'b1;
         end
         OP_STORE: dec_mw = 1'b1;
         OP_BRANCH: begin
            dec_s2   = S2_RS;
            dec_ctrl = (id_funct3[2:1] == 2'b00) ? ALU_SUB : ALU_SLT;
         end
         OP_JAL, OP_JALR: begin
            dec_s1 = S1_PC;
            dec_s2 = S2_FOUR;
            dec_rw = 1'b1;
         end
         OP_LUI: begin
            dec_s1 = S1_ZERO;
            dec_rw = 1'b1;
         end
         OP_AUIPC: begin
            dec_s1 = S1_PC;
            dec_rw = 1'b1;
         end
         default: ;
      endcase
   end

   // Only a load already in EX can create a hazard, since memread_q is already qualified by valid
   assign load_use_stall = valid_q & memread_q & id_valid & (rd_q != '0) &
                           ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr));

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_d       = rd_q;
      ctrl_d     = ctrl_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      if (flush || (!hold && load_use_stall)) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         ctrl_d     = ALU_ADD;
      end else if (!hold) begin
         valid_d    = id_valid;
         pc_d       = id_pc;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         rs1_addr_d = id_rs1_addr;
         rs2_addr_d = id_rs2_addr;
         rd_d       = id_rd_addr;
         ctrl_d     = dec_ctrl;
         regwrite_d = id_valid & dec_rw;
         memread_d  = id_valid & dec_mr;
         memwrite_d = id_valid & dec_mw;
         s1_d       = dec_s1;
         s2_d       = dec_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_q       <= '0;
         ctrl_q     <= ALU_ADD;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         s1_q       <= S1_RS;
         s2_q       <= S2_RS;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_q       <= rd_d;
         ctrl_q     <= ctrl_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   // EX/MEM is the younger result, so it takes precedence; x0 is hard-wired zero and never forwarded
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [RF_AW-1:0] ra,
      input logic [XLEN-1:0]  latched,
      input logic             em_we,
      input logic [RF_AW-1:0] em_rd,
      input logic [XLEN-1:0]  em_val,
      input logic             mw_we,
      input logic [RF_AW-1:0] mw_rd,
      input logic [XLEN-1:0]  mw_val
   );
      if (em_we && em_rd != '0 && em_rd == ra)
         return em_val;
      else if (mw_we && mw_rd != '0 && mw_rd == ra)
         return mw_val;
      else
         return latched;
   endfunction

   always_comb begin
      fwd_rs1 = fwd_sel(rs1_addr_q, rs1_data_q, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_data);
      fwd_rs2 = fwd_sel(rs2_addr_q, rs2_data_q, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_data);
   end

   always_comb begin
      case (s1_q)
         S1_PC:   alu_src1 = pc_q;
         S1_ZERO: alu_src1 = '0;
         default: alu_src1 = fwd_rs1;
      endcase
      case (s2_q)
         S2_FOUR: alu_src2 = XLEN'(4);
         S2_IMM:  alu_src2 = imm_q;
         default: alu_src2 = fwd_rs2;
      endcase
   end

   assign ex_valid      = valid_q;
   assign alu_ctrl      = ctrl_q;
   assign ex_rd         = rd_q;
   assign ex_regwrite   = regwrite_q;
   assign ex_memread    = memread_q;
   assign ex_memwrite   = memwrite_q;
   assign ex_store_data = fwd_rs2;
   assign ex_pc         = pc_q;

`ifdef EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (load_use_stall && !flush && !hold && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: decode vector table, hand-written hazard/flush/hold/reset sequences, random run vs model.
module tb_ex_operand_stage;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   // ALU code per funct3 for R/I ops, nibble n = funct3 n
   localparam logic [31:0] F3MAP = {4'd0, 4'd1, 4'd7, 4'd4, 4'd5, 4'd5, 4'd6, 4'd2};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic        id_funct7_5;
   logic        flush, hold;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_data;
   logic        load_use_stall, ex_valid;
   logic [31:0] alu_src1, alu_src2, ex_store_data, ex_pc;
   logic [3:0]  alu_ctrl;
   logic [4:0]  ex_rd;
   logic        ex_regwrite, ex_memread, ex_memwrite;
`ifdef EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   ex_operand_stage #(.XLEN(32), .RF_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
      .flush(flush), .hold(hold),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_store_data(ex_store_data),
`ifdef EX_STALL_CNT_EN
      .ex_pc(ex_pc), .stall_cnt(stall_cnt)
`else
      .ex_pc(ex_pc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] pc, a, b, imm;
      logic [3:0]  ctrl;
      logic [31:0] s1, s2;
      logic        rw, mr, mw;
   } vec_t;

   typedef struct {
      logic        v;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  r1, r2, rd;
   } ins_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd);
      id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7_5 = f7;
      id_pc = pc; id_rs1_data = a; id_rs2_data = b; id_imm = imm;
      id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
   endtask

   task automatic no_fwd();
      exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: ALU operation and operand choice derived from the instruction class
   function automatic logic [3:0] m_ctrl(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      logic [3:0] r;
      r = 4'd2;
      if (op == OP_R || op == OP_I) begin
         r = F3MAP[f3*4 +: 4];
         if (f3 == 3'd0 && op == OP_R && f7) r = 4'd3;
         if (f3 == 3'd5 && f7) r = 4'd8;
      end else if (op == OP_BRANCH) begin
         r = (f3 < 3'd2) ? 4'd3 : 4'd5;
      end
      return r;
   endfunction

   function automatic logic m_rw(input logic [6:0] op);
      return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_JAL ||
             op == OP_JALR || op == OP_LUI || op == OP_AUIPC;
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] lat);
      if (exmem_regwrite && exmem_rd != 0 && exmem_rd == r) return exmem_result;
      if (memwb_regwrite && memwb_rd != 0 && memwb_rd == r) return memwb_data;
      return lat;
   endfunction

   function automatic logic [31:0] m_src1(input ins_t m);
      if (m.op == OP_JAL || m.op == OP_JALR || m.op == OP_AUIPC) return m.pc;
      if (m.op == OP_LUI) return 32'd0;
      return m_fwd(m.r1, m.a);
   endfunction

   function automatic logic [31:0] m_src2(input ins_t m);
      if (m.op == OP_R || m.op == OP_BRANCH) return m_fwd(m.r2, m.b);
      if (m.op == OP_JAL || m.op == OP_JALR) return 32'd4;
      return m.imm;
   endfunction

   vec_t vt[19];
   ins_t m;
   logic [31:0] exp_cnt;
   logic        exp_stall;
   logic [6:0]  ops[9];

   initial begin
      vt[0]  = '{OP_R,      3'b000, 1'b1, 32'h0,   32'd10,    32'd3, 32'h0,        4'd3, 32'd10,    32'd3,        1, 0, 0};
      vt[1]  = '{OP_R,      3'b000, 1'b0, 32'h4,   32'd7,     32'd5, 32'h0,        4'd2, 32'd7,     32'd5,        1, 0, 0};
      vt[2]  = '{OP_I,      3'b000, 1'b1, 32'h8,   32'd7,     32'd5, 32'h20,       4'd2, 32'd7,     32'h20,       1, 0, 0};
      vt[3]  = '{OP_I,      3'b101, 1'b1, 32'hC,   32'h80,    32'd1, 32'h403,      4'd8, 32'h80,    32'h403,      1, 0, 0};
      vt[4]  = '{OP_R,      3'b101, 1'b0, 32'h10,  32'h80,    32'd2, 32'h0,        4'd7, 32'h80,    32'd2,        1, 0, 0};
      vt[5]  = '{OP_R,      3'b011, 1'b0, 32'h14,  32'd1,     32'd9, 32'h0,        4'd5, 32'd1,     32'd9,        1, 0, 0};
      vt[6]  = '{OP_I,      3'b100, 1'b0, 32'h18,  32'hF0,    32'd9, 32'hFF,       4'd4, 32'hF0,    32'hFF,       1, 0, 0};
      vt[7]  = '{OP_R,      3'b110, 1'b0, 32'h1C,  32'h1,     32'h2, 32'h0,        4'd1, 32'h1,     32'h2,        1, 0, 0};
      vt[8]  = '{OP_I,      3'b111, 1'b0, 32'h20,  32'hFF,    32'h2, 32'h0F,       4'd0, 32'hFF,    32'h0F,       1, 0, 0};
      vt[9]  = '{OP_R,      3'b001, 1'b0, 32'h24,  32'h1,     32'h4, 32'h0,        4'd6, 32'h1,     32'h4,        1, 0, 0};
      vt[10] = '{OP_LOAD,   3'b010, 1'b0, 32'h28,  32'h1000,  32'h4, 32'h8,        4'd2, 32'h1000,  32'h8,        1, 1, 0};
      vt[11] = '{OP_STORE,  3'b010, 1'b0, 32'h2C,  32'h2000,  32'h5, 32'hC,        4'd2, 32'h2000,  32'hC,        0, 0, 1};
      vt[12] = '{OP_BRANCH, 3'b000, 1'b0, 32'h30,  32'd6,     32'd6, 32'h40,       4'd3, 32'd6,     32'd6,        0, 0, 0};
      vt[13] = '{OP_BRANCH, 3'b100, 1'b0, 32'h34,  32'd6,     32'd7, 32'h40,       4'd5, 32'd6,     32'd7,        0, 0, 0};
      vt[14] = '{OP_JAL,    3'b000, 1'b0, 32'h100, 32'h55,    32'h66, 32'h80,      4'd2, 32'h100,   32'd4,        1, 0, 0};
      vt[15] = '{OP_JALR,   3'b000, 1'b0, 32'h200, 32'h55,    32'h66, 32'h80,      4'd2, 32'h200,   32'd4,        1, 0, 0};
      vt[16] = '{OP_LUI,    3'b000, 1'b0, 32'h300, 32'h55,    32'h66, 32'h12345000, 4'd2, 32'h0,    32'h12345000, 1, 0, 0};
      vt[17] = '{OP_AUIPC,  3'b000, 1'b0, 32'h40,  32'h55,    32'h66, 32'h1000,    4'd2, 32'h40,    32'h1000,     1, 0, 0};
      vt[18] = '{7'b1111111, 3'b000, 1'b0, 32'h44, 32'h55,    32'h66, 32'h77,      4'd2, 32'h55,    32'h77,       0, 0, 0};
      ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

      // reset state
      rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
      drv(0, 7'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      no_fwd();
      #12;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_ctrl", 32'(alu_ctrl), 32'd2);
      chk("rst_en", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 32'd0);
      chk("rst_pc", ex_pc, 32'd0);
`ifdef EX_STALL_CNT_EN
      chk("rst_cnt", stall_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // decode table
      for (int i = 0; i < 19; i++) begin
         drv(1, vt[i].op, vt[i].f3, vt[i].f7, vt[i].pc, vt[i].a, vt[i].b, vt[i].imm, 5'd1, 5'd2, 5'd9);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
         chk($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(vt[i].ctrl));
         chk($sformatf("v%0d_src1", i), alu_src1, vt[i].s1);
         chk($sformatf("v%0d_src2", i), alu_src2, vt[i].s2);
         chk($sformatf("v%0d_en", i), {29'd0, ex_regwrite, ex_memread, ex_memwrite},
             {29'd0, vt[i].rw, vt[i].mr, vt[i].mw});
         chk($sformatf("v%0d_sd", i), ex_store_data, vt[i].b);
         chk($sformatf("v%0d_pc", i), ex_pc, vt[i].pc);
         chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'd9);
      end

      // forwarding priority
      drv(1, OP_R, 3'b000, 0, 32'h50, 32'h55, 32'h66, 0, 5'd5, 5'd6, 5'd10);
      tick();
      drv(0, 7'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'h11;
      memwb_regwrite = 1; memwb_rd = 5; memwb_data = 32'h22;
      #1 chk("fwd_exmem", alu_src1, 32'h11);
      exmem_regwrite = 0;
      #1 chk("fwd_memwb", alu_src1, 32'h22);
      memwb_rd = 0; exmem_rd = 0; exmem_regwrite = 1;
      #1 chk("fwd_x0", alu_src1, 32'h55);
      memwb_rd = 6;
      #1 chk("fwd_rs2", alu_src2, 32'h22);
      chk("fwd_sd", ex_store_data, 32'h22);
      no_fwd();
      tick();

      // load-use: LW x7 then ADD x8,x7,x1
      drv(1, OP_LOAD, 3'b010, 0, 32'h60, 32'h100, 0, 32'h4, 5'd1, 5'd2, 5'd7);
      tick();
      chk("lu_nostall_pre", 32'(load_use_stall), 32'd0);
      drv(1, OP_R, 3'b000, 0, 32'h64, 32'h3, 32'h4, 0, 5'd7, 5'd1, 5'd8);
      #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
      tick();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_en", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 32'd0);
      chk("lu_stall_gone", 32'(load_use_stall), 32'd0);
      tick();
      chk("lu_add_valid", 32'(ex_valid), 32'd1);
      chk("lu_add_ctrl", 32'(alu_ctrl), 32'd2);
      chk("lu_add_rd", 32'(ex_rd), 32'd8);
`ifdef EX_STALL_CNT_EN
      chk("lu_cnt", stall_cnt, 32'd1);
`endif

      // flush beats hold
      drv(1, OP_R, 3'b000, 1, 32'h70, 32'd20, 32'd5, 0, 5'd1, 5'd2, 5'd3);
      tick();
      hold = 1; flush = 1;
      drv(1, OP_I, 3'b000, 0, 32'h74, 32'd1, 32'd1, 32'd1, 5'd1, 5'd2, 5'd4);
      tick();
      chk("flush_hold_valid", 32'(ex_valid), 32'd0);
      chk("flush_hold_rw", 32'(ex_regwrite), 32'd0);
      hold = 0; flush = 0;
      drv(1, OP_R, 3'b000, 1, 32'h80, 32'd20, 32'd5, 0, 5'd1, 5'd2, 5'd3);
      tick();
      hold = 1;
      for (int k = 0; k < 3; k++) begin
         drv(1, OP_I, 3'b110, 0, 32'h90 + k, 32'd99, 32'd98, 32'd97, 5'd4, 5'd5, 5'd6);
         tick();
         chk($sformatf("hold%0d_valid", k), 32'(ex_valid), 32'd1);
         chk($sformatf("hold%0d_ctrl", k), 32'(alu_ctrl), 32'd3);
         chk($sformatf("hold%0d_src", k), alu_src1 ^ {alu_src2[15:0], 16'd0}, 32'd20 ^ {16'd5, 16'd0});
         chk($sformatf("hold%0d_pc", k), ex_pc, 32'h80);
         chk($sformatf("hold%0d_rd", k), 32'(ex_rd), 32'd3);
      end
      hold = 0;

      // async reset with SRAI loaded
      drv(1, OP_I, 3'b101, 1, 32'hA0, 32'h80, 0, 32'h402, 5'd1, 5'd2, 5'd3);
      tick();
      chk("srai_ctrl", 32'(alu_ctrl), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ex_valid), 32'd0);
      chk("arst_ctrl", 32'(alu_ctrl), 32'd2);
      chk("arst_rw", 32'(ex_regwrite), 32'd0);
`ifdef EX_STALL_CNT_EN
      chk("arst_cnt", stall_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      m = '{default: '0};
      exp_cnt = '0;
      drv(0, 7'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // random run against the model
      for (int c = 0; c < 400; c++) begin
         drv($urandom_range(0, 3) != 0,
             ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)],
             3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         flush = ($urandom_range(0, 9) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
         memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
         #1;
         exp_stall = m.v && m.op == OP_LOAD && id_valid && m.rd != 0 &&
                     (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
         chk("r_stall", 32'(load_use_stall), 32'(exp_stall));
         chk("r_valid", 32'(ex_valid), 32'(m.v));
         chk("r_en", {29'd0, ex_regwrite, ex_memread, ex_memwrite},
             {29'd0, m.v & m_rw(m.op), m.v & (m.op == OP_LOAD), m.v & (m.op == OP_STORE)});
         if (m.v) begin
            chk("r_ctrl", 32'(alu_ctrl), 32'(m_ctrl(m.op, m.f3, m.f7)));
            chk("r_src1", alu_src1, m_src1(m));
            chk("r_src2", alu_src2, m_src2(m));
            chk("r_sd", ex_store_data, m_fwd(m.r2, m.b));
            chk("r_rd", 32'(ex_rd), 32'(m.rd));
            chk("r_pc", ex_pc, m.pc);
         end
`ifdef EX_STALL_CNT_EN
         chk("r_cnt", stall_cnt, exp_cnt);
         if (exp_stall && !flush && !hold && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
         if (flush || (!hold && exp_stall)) begin
            m.v = 1'b0;
         end else if (!hold) begin
            m = '{id_valid, id_opcode, id_funct3, id_funct7_5, id_pc, id_rs1_data, id_rs2_data,
                  id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr};
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
